// File: rtl/pwm_multi_if.sv
// Button/mode inputs and PWM outputs of pwm_multi, bundled as one port.
// The master side drives buttons, channel select and mode; the slave
// side (the PWM block) drives the PWM pins and the period marker.
interface pwm_multi_if #(
    parameter int CHANNELS = 2,
    parameter int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
    logic                inc_btn;
    logic                dec_btn;
    logic [SEL_W-1:0]    ch_sel;
    logic                mode;
    logic [CHANNELS-1:0] pwm_out;
    logic                period_start;

    modport master (
        output inc_btn,
        output dec_btn,
        output ch_sel,
        output mode,
        input  pwm_out,
        input  period_start
    );

    modport slave (
        input  inc_btn,
        input  dec_btn,
        input  ch_sel,
        input  mode,
        output pwm_out,
        output period_start
    );
endinterface

// File: rtl/pwm_multi.sv
// Multi-channel PWM generator with debounced push-button duty control.
// Each channel keeps a pending duty that the buttons adjust; the active
// duty and the alignment mode are copied in only when a new period starts,
// so every period is produced from one consistent set of values.
module pwm_multi #(
    parameter int CHANNELS  = 2,
    parameter int CNT_W     = 4,
    parameter int PERIOD    = 10,
    parameter int STEP      = 1,
    parameter int INIT_DUTY = 5,
    parameter int DEB_DIV   = 2
) (
    input  logic       clk,
    input  logic       reset,
    pwm_multi_if.slave bus
);
    localparam int DIV_W = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(DEB_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] PERIOD_V   = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0] INIT_V     = CNT_W'(INIT_DUTY);
    localparam logic [CNT_W:0]   PERIOD_X   = (CNT_W + 1)'(PERIOD);
    localparam logic [CNT_W:0]   STEP_X     = (CNT_W + 1)'(STEP);
    localparam logic [31:0]      CHANNELS_U = 32'(CHANNELS);

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Add one step, clamped at the full-period duty (computed one bit wider
    // so the sum cannot wrap).
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] d);
        logic [CNT_W:0] sum;
        sum = {1'b0, d} + STEP_X;
        if (sum > PERIOD_X) begin
            sat_inc = PERIOD_V;
        end else begin
            sat_inc = sum[CNT_W-1:0];
        end
    endfunction

    // Subtract one step, clamped at zero; the compare precedes the
    // subtraction so the result never underflows.
    function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] d);
        logic [CNT_W:0] d_x;
        d_x = {1'b0, d};
        if (d_x < STEP_X) begin
            sat_dec = '0;
        end else begin
            sat_dec = d - STEP_X[CNT_W-1:0];
        end
    endfunction

    logic [DIV_W-1:0]    div_r;
    logic                tick_s;
    logic                inc_s1_r, inc_s2_r;
    logic                dec_s1_r, dec_s2_r;
    logic                inc_ev_s, dec_ev_s;
    logic [31:0]         sel_idx_s;
    logic                sel_ok_s;
    logic [CNT_W-1:0]    duty_r     [CHANNELS];
    logic [CNT_W-1:0]    duty_nxt_s [CHANNELS];
    logic [CNT_W-1:0]    act_r      [CHANNELS];
    logic [CNT_W-1:0]    cnt_r, cnt_nxt_s;
    dir_e                dir_r, dir_nxt_s;
    logic                mode_q_r;
    logic                boundary_s;
    logic [CHANNELS-1:0] pwm_s;

    assign tick_s   = (div_r == DIV_LAST);
    assign inc_ev_s = tick_s & inc_s1_r & ~inc_s2_r;
    assign dec_ev_s = tick_s & dec_s1_r & ~dec_s2_r;

    // Free-running divider producing the debounce sampling tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_r <= '0;
        end else if (tick_s) begin
            div_r <= '0;
        end else begin
            div_r <= div_r + DIV_W'(1);
        end
    end

    // Two-stage button samplers that only move on a tick, so a bouncing
    // contact is seen at the slow tick rate and one hold gives one edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inc_s1_r <= 1'b0;
            inc_s2_r <= 1'b0;
            dec_s1_r <= 1'b0;
            dec_s2_r <= 1'b0;
        end else if (tick_s) begin
            inc_s1_r <= bus.inc_btn;
            inc_s2_r <= inc_s1_r;
            dec_s1_r <= bus.dec_btn;
            dec_s2_r <= dec_s1_r;
        end
    end

    // Pending-duty update: one saturating step on the selected channel;
    // colliding inc/dec events or an out-of-range channel change nothing.
    always_comb begin
        sel_idx_s = 32'(bus.ch_sel);
        sel_ok_s  = (sel_idx_s < CHANNELS_U);
        for (int i = 0; i < CHANNELS; i++) begin
            duty_nxt_s[i] = duty_r[i];
            if (sel_ok_s && (sel_idx_s == 32'(i))) begin
                if (inc_ev_s && !dec_ev_s) begin
                    duty_nxt_s[i] = sat_inc(duty_r[i]);
                end else if (dec_ev_s && !inc_ev_s) begin
                    duty_nxt_s[i] = sat_dec(duty_r[i]);
                end else begin
                    duty_nxt_s[i] = duty_r[i];
                end
            end else begin
                duty_nxt_s[i] = duty_r[i];
            end
        end
    end

    // Pending-duty registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                duty_r[i] <= INIT_V;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                duty_r[i] <= duty_nxt_s[i];
            end
        end
    end

    // Period counter next state: sawtooth in edge mode, up/down triangle
    // with doubled endpoints in center mode; flags the edge that opens a
    // new period.
    always_comb begin
        cnt_nxt_s  = cnt_r;
        dir_nxt_s  = dir_r;
        boundary_s = 1'b0;
        if (!mode_q_r) begin
            dir_nxt_s = DIR_UP;
            if (cnt_r >= CNT_LAST) begin
                cnt_nxt_s  = '0;
                boundary_s = 1'b1;
            end else begin
                cnt_nxt_s = cnt_r + CNT_W'(1);
            end
        end else begin
            case (dir_r)
                DIR_UP: begin
                    if (cnt_r >= CNT_LAST) begin
                        cnt_nxt_s = CNT_LAST;
                        dir_nxt_s = DIR_DOWN;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_W'(1);
                    end
                end
                DIR_DOWN: begin
                    if (cnt_r == '0) begin
                        cnt_nxt_s  = '0;
                        dir_nxt_s  = DIR_UP;
                        boundary_s = 1'b1;
                    end else begin
                        cnt_nxt_s = cnt_r - CNT_W'(1);
                    end
                end
                default: begin
                    cnt_nxt_s  = '0;
                    dir_nxt_s  = DIR_UP;
                    boundary_s = 1'b1;
                end
            endcase
        end
    end

    // Counter state plus the shadow copies of duty and mode, refreshed only
    // on a period boundary; a press landing on that same edge waits a period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r    <= '0;
            dir_r    <= DIR_UP;
            mode_q_r <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                act_r[i] <= INIT_V;
            end
        end else begin
            cnt_r <= cnt_nxt_s;
            dir_r <= dir_nxt_s;
            if (boundary_s) begin
                mode_q_r <= bus.mode;
                for (int i = 0; i < CHANNELS; i++) begin
                    act_r[i] <= duty_r[i];
                end
            end
        end
    end

    // PWM compare against the active duty: low-aligned in edge mode,
    // centred on the turnaround in center mode.
    always_comb begin
        pwm_s = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (mode_q_r) begin
                pwm_s[i] = ({1'b0, cnt_r} >= (PERIOD_X - {1'b0, act_r[i]}));
            end else begin
                pwm_s[i] = (cnt_r < act_r[i]);
            end
        end
    end

    assign bus.pwm_out      = pwm_s;
    assign bus.period_start = (cnt_r == '0) && (dir_r == DIR_UP);

endmodule

// File: doc/pwm_multi.md
# pwm_multi

Multi-channel PWM generator with debounced push-button duty control. It is the parametrised successor to the single-channel 10-step PWM. The block adds a configurable channel count, period and step, and glitch-free shadowed duty updates. It also has an edge-aligned or center-aligned mode and an asynchronous reset. It sits between the board-level button inputs and the PWM output pins.

## Interface
- CHANNELS, 2, number of independent PWM outputs (1..8)
- CNT_W, 4, width of period counter and duty registers; PERIOD must be ≤ 2^CNT_W − 1
- PERIOD, 10, counter steps per edge-aligned period (≥ 2)
- STEP, 1, duty change per accepted button press
- INIT_DUTY, 5, duty loaded into every channel at reset (≤ PERIOD)
- DEB_DIV, 2, clocks per debounce sampling tick (≥ 1; 25000000 for 4 Hz on a 100 MHz board)
- clk  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- inc_btn  in  1  raw increase button
- dec_btn  in  1  raw decrease button
- ch_sel  in  max(1,clog2(CHANNELS))  channel targeted by button presses
- mode  in  1  0 = edge-aligned, 1 = center-aligned
- pwm_out  out  CHANNELS  PWM outputs, bit i = channel i
- period_start  out  1  high during the first clock of every PWM period

## Operation
- **Tick divider.**
  - div counts 0..DEB_DIV−1 and wraps.
  - tick = (div == DEB_DIV−1).
- **Debounce, per button.**
  - On each tick: s1 <= btn and s2 <= s1. Both registers hold between ticks.
  - Press event = tick & s1 & ~s2. This gives exactly one event per sampled rising edge, regardless of hold time.
- **Duty update.** Each channel has a pending duty register duty[i], CNT_W bits.
  - On an inc event: duty[ch_sel] <= min(duty + STEP, PERIOD).
  - On a dec event: duty[ch_sel] <= max(duty − STEP, 0), computed without underflow.
  - inc and dec events in the same cycle: no change.
  - ch_sel ≥ CHANNELS: event ignored.
  - ch_sel is sampled in the event cycle.
- **Shadowing.**
  - act[i] <= duty[i] for all channels at every period boundary (the clock edge that starts a new period).
  - mode_q <= mode at the same boundary.
  - Outputs use only act and mode_q, so each period is glitch-free.
- **Edge-aligned mode (mode_q = 0).**
  - cnt runs 0..PERIOD−1 and wraps to 0.
  - Period = PERIOD clocks.
  - pwm_out[i] = (cnt < act[i]).
- **Center-aligned mode (mode_q = 1).**
  - cnt counts up 0..PERIOD−1, then down PERIOD−1..0. Each endpoint is held for two clocks.
  - dir flag selects the phase. Period = 2·PERIOD clocks.
  - pwm_out[i] = (cnt ≥ PERIOD − act[i]), giving 2·act[i] high clocks centred on the turnaround.
- **Period boundary.**
  - period_start = (cnt == 0 && dir == up).
  - In edge mode dir is always up.
  - On a mode change the counter restarts cleanly: cnt = 0, dir = up.
- **Duty extremes.**
  - act = 0: output constantly low.
  - act = PERIOD: output constantly high in both modes.

## Timing
- **Reset values, while reset is high:**
  - div = 0, s1 = s2 = 0, cnt = 0, dir = up, mode_q = 0.
  - duty[i] = act[i] = INIT_DUTY.
  - pwm_out = all ones if INIT_DUTY > 0, else all zeros.
  - period_start = 1.
- **Reset mid-period.** Outputs jump to the reset values asynchronously. The first period after release starts at cnt = 0.
- **pwm_out and period_start** are combinational from registers, with no extra latency.
- **Button latency.**
  - The button must be high across one tick edge to load s1.
  - The event fires on the next tick, and duty changes at that clock edge.
  - Worst case is 2·DEB_DIV + 1 clocks from button rise to duty change.
  - Output reflects the change from the next period_start.
- **Boundary timing.** A press landing on the same clock edge as a period boundary is not included in that boundary's load: act gets the old duty. It takes effect one period later.

## Test plan
- **Reset and default duty.** Defaults, hold reset 3 clocks, release → pwm_out[0] and pwm_out[1] each high 5 of every 10 clocks; period_start pulses every 10 clocks.
- **Single press per hold.** ch_sel = 0, inc_btn held 40 clocks → duty[0] = 6 (exactly one step); from the next period, channel 0 is high 6/10 and channel 1 is still 5/10.
- **Saturation both ways.** Six separate inc presses on ch1 → duty 10, pwm_out[1] constantly 1. Twelve dec presses → duty 0, constantly 0, with no wrap.
- **Simultaneous and invalid events.** inc_btn and dec_btn rise together → duty unchanged. With CHANNELS = 3, ch_sel = 3 plus a press → no channel changes.
- **Center-aligned mode.**
  - Set mode = 1 mid-period → the change is applied only at the next period_start.
  - Then period = 20 clocks; with duty 3, output is high for the 6 contiguous clocks where cnt is 7, 8, 9, 9, 8, 7.
- **Reset mid-operation.** After duty = 8 and mode = 1, assert reset on an arbitrary clock → immediately cnt = 0, pwm_out = 1, duty back to 5, edge mode restored.
